uart_tx: RTL and testbench

//  - UART transmitter, 8N1 framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
//  - Accepts a byte on a single-cycle start strobe and drives the serial line at a fixed baud rate.
//  - Sits between the byte-producing logic and the TX pad; reports busy for the full frame.

---
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// A byte is accepted on tx_start while idle; tx_out and tx_busy come straight from flops.
module uart_tx #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx_out,
    output logic       tx_busy
);

    localparam int BAUD_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W       = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_next_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_next_s;
    logic [CNT_W-1:0]  baud_cnt_r;
    logic [CNT_W-1:0]  baud_cnt_next_s;
    logic              tx_next_s;
    logic              busy_next_s;
    logic              baud_tick_s;

    assign baud_tick_s = (baud_cnt_r == CNT_MAX);

    // Next-state, next-output and datapath update for the frame sequencer
    always_comb begin
        state_next_s    = state_r;
        shift_next_s    = shift_r;
        bit_idx_next_s  = bit_idx_r;
        baud_cnt_next_s = baud_cnt_r;
        tx_next_s       = tx_out;
        busy_next_s     = tx_busy;

        case (state_r)
            ST_IDLE: begin
                tx_next_s       = 1'b1;
                busy_next_s     = 1'b0;
                baud_cnt_next_s = CNT_ZERO;
                if (tx_start) begin
                    // The start bit appears on the very edge that accepts the byte
                    shift_next_s   = data_in;
                    bit_idx_next_s = 3'd0;
                    tx_next_s      = 1'b0;
                    busy_next_s    = 1'b1;
                    state_next_s   = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (baud_tick_s) begin
                    baud_cnt_next_s = CNT_ZERO;
                    tx_next_s       = shift_r[0];
                    shift_next_s    = {1'b0, shift_r[7:1]};
                    bit_idx_next_s  = 3'd0;
                    state_next_s    = ST_DATA;
                end else begin
                    baud_cnt_next_s = baud_cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (baud_tick_s) begin
                    baud_cnt_next_s = CNT_ZERO;
                    if (bit_idx_r < 3'd7) begin
                        tx_next_s      = shift_r[0];
                        shift_next_s   = {1'b0, shift_r[7:1]};
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end else begin
                        tx_next_s    = 1'b1;
                        state_next_s = ST_STOP;
                    end
                end else begin
                    baud_cnt_next_s = baud_cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                tx_next_s = 1'b1;
                if (baud_tick_s) begin
                    baud_cnt_next_s = CNT_ZERO;
                    busy_next_s     = 1'b0;
                    state_next_s    = ST_IDLE;
                end else begin
                    baud_cnt_next_s = baud_cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_next_s    = ST_IDLE;
                baud_cnt_next_s = CNT_ZERO;
                bit_idx_next_s  = 3'd0;
                tx_next_s       = 1'b1;
                busy_next_s     = 1'b0;
            end
        endcase
    end

    // State, datapath and registered line outputs; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            baud_cnt_r <= CNT_ZERO;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            shift_r    <= shift_next_s;
            bit_idx_r  <= bit_idx_next_s;
            baud_cnt_r <= baud_cnt_next_s;
            tx_out     <= tx_next_s;
            tx_busy    <= busy_next_s;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: a frame-level reference model queues the expected
// line/busy value for every clock edge, and a falling-edge monitor compares the DUT.
module tb_uart_tx;

    localparam int TB_BAUD = 9600;
    localparam int B       = 16;
    localparam int TB_CLK  = TB_BAUD * B;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] data_in;
    logic       tx_out;
    logic       tx_busy;

    int vectors;
    int miscompares;

    logic [1:0] exp_q[$];

    int unsigned edge_n;
    bit          active;
    int unsigned fk;
    logic [9:0]  fbits;

    uart_tx #(
        .CLK_FREQ (TB_CLK),
        .BAUD_RATE(TB_BAUD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .data_in (data_in),
        .tx_out  (tx_out),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A frame accepted at edge k puts frame bit n on the line from edge k+n*B; busy covers edges k..k+10B-1.
    task automatic model_step();
        logic exp_tx;
        logic exp_busy;
        if (reset) begin
            active = 1'b0;
        end else if (tx_start && (!active || (edge_n - fk) > 10 * B)) begin
            active = 1'b1;
            fk     = edge_n;
            fbits  = {1'b1, data_in, 1'b0};
        end
        if (active && (edge_n - fk) < 10 * B) begin
            exp_tx   = fbits[(edge_n - fk) / B];
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
        exp_q.push_back({exp_tx, exp_busy});
        edge_n++;
    endtask

    initial begin
        edge_n = 0;
        active = 1'b0;
        fk     = 0;
        fbits  = 10'h3FF;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: the DUT presents a new line state every cycle; compare it on the falling edge
    initial begin
        logic [1:0] e;
        vectors     = 0;
        miscompares = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({tx_out, tx_busy} !== e) begin
                    miscompares++;
                    $display("FAIL line t=%0t: tx_out=%b tx_busy=%b, expected tx_out=%b tx_busy=%b",
                             $time, tx_out, tx_busy, e[1], e[0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d);
        tx_start = 1'b1;
        data_in  = d;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        data_in  = 8'($urandom);
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 * B; i++) begin
            @(negedge clk);
            if (!tx_busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: tx_busy=%b after %0d cycles, expected 0", tx_busy, 20 * B);
        end
    endtask

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        data_in  = 8'h00;
        step(5);
        reset = 1'b0;
        step(3);

        // Single 'A' frame
        pulse(8'h41);
        step(2);
        wait_idle();

        // Two frames back to back, each launched as soon as busy drops
        pulse(8'h62);
        step(2);
        wait_idle();
        pulse(8'h34);
        step(2);
        wait_idle();
        step(4);

        // Mid-frame start request and data change are ignored
        pulse(8'h55);
        step(3 * B);
        pulse(8'hAA);
        data_in = 8'h0F;
        step(2 * B);
        wait_idle();
        step(4);

        // Reset during data bit 4 aborts, then a clean frame follows
        pulse(8'hC3);
        step(4 * B + 5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(3);
        pulse(8'h5A);
        step(2);
        wait_idle();
        step(3);

        // tx_start held high across three frames
        tx_start = 1'b1;
        data_in  = 8'h96;
        step(3 * (10 * B + 1) - 5);
        tx_start = 1'b0;
        wait_idle();
        step(3);

        // Random bytes, gaps and spurious mid-frame requests
        for (int i = 0; i < 12; i++) begin
            pulse(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                step($urandom_range(1, 9 * B));
                pulse(8'($urandom));
            end else begin
                step(1);
            end
            wait_idle();
            step($urandom_range(0, 3));
        end

        step(5);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
